// File: rtl/gpu_pkg.sv
`default_nettype none
// gpu_pkg - shared sprite types, geometry constants and evaluator state encoding.
// Rev 1.0
package gpu_pkg;
  localparam int COORD_W  = 16;
  localparam int SIZE_W   = 3;
  localparam int LINE_W   = 10;
  localparam int TILE_PX  = 8;
  localparam int TS       = $clog2(TILE_PX);
  localparam int SCREEN_W = 640;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_EMIT  = 3'd4,
    ST_FIN   = 3'd5
  } eval_state_t;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic [SIZE_W-1:0]         sx;
    logic [SIZE_W-1:0]         sy;
    logic                      vflip;
    logic [3:0]                tiley;
  } sprite_attr_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [3:0]         tile_row;
    logic [TS-1:0]      row_off;
    logic [SIZE_W-1:0]  first;
    logic [SIZE_W-1:0]  last;
  } sprite_hit_t;
endpackage
`default_nettype wire

// File: rtl/sprite_line_eval_if.sv
`default_nettype none
// sprite_line_eval_if - control, attribute-RAM and hit-stream bundle of the line evaluator.
// Rev 1.0
interface sprite_line_eval_if #(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 8
);
  import gpu_pkg::*;
  localparam int IW = $clog2(NUM_SPRITES);
  localparam int CW = $clog2(MAX_PER_LINE + 1);

  logic                start;
  logic [LINE_W-1:0]   line;
  logic                busy;
  logic                done;
  logic [CW-1:0]       hit_count;
  logic                overflow;
  logic                attr_rd;
  logic [IW-1:0]       attr_addr;
  logic [COORD_W-1:0]  attr_x;
  logic [COORD_W-1:0]  attr_y;
  logic [SIZE_W-1:0]   attr_sx;
  logic [SIZE_W-1:0]   attr_sy;
  logic                attr_vflip;
  logic [3:0]          attr_tiley;
  logic                hit_valid;
  logic                hit_ready;
  logic [IW-1:0]       hit_index;
  logic [COORD_W-1:0]  hit_x;
  logic [3:0]          hit_tile_row;
  logic [TS-1:0]       hit_row_off;
  logic [SIZE_W-1:0]   hit_first;
  logic [SIZE_W-1:0]   hit_last;

  modport master (
    input  start, line, attr_x, attr_y, attr_sx, attr_sy, attr_vflip, attr_tiley, hit_ready,
    output busy, done, hit_count, overflow, attr_rd, attr_addr,
           hit_valid, hit_index, hit_x, hit_tile_row, hit_row_off, hit_first, hit_last
  );

  modport slave (
    output start, line, attr_x, attr_y, attr_sx, attr_sy, attr_vflip, attr_tiley, hit_ready,
    input  busy, done, hit_count, overflow, attr_rd, attr_addr,
           hit_valid, hit_index, hit_x, hit_tile_row, hit_row_off, hit_first, hit_last
  );
endinterface
`default_nettype wire

// File: rtl/sprite_geom.sv
`default_nettype none
// sprite_geom - combinational per-sprite line intersect, tile row/offset and visible columns.
// Rev 1.0; SPRITE_XCLIP_EN adds the horizontal on-screen test and first/last column clipping.
module sprite_geom
  import gpu_pkg::*;
(
  input  sprite_attr_t      i_attr,
  input  logic [LINE_W-1:0] i_line,
  output logic              o_hit,
  output sprite_hit_t       o_rec
);
  localparam int DW = COORD_W + 1;
  localparam int NW = SIZE_W + TS;

  logic [NW-1:0]        w_h;
  logic [NW-1:0]        w_n;
  logic signed [DW-1:0] w_d;
  logic                 w_hit_y;

  // ((s+1)<<TS)-1 is just the size code with TS ones appended
  assign w_h     = {i_attr.sy, {TS{1'b1}}};
  assign w_d     = $signed({{(DW-LINE_W){1'b0}}, i_line}) - $signed({i_attr.y[COORD_W-1], i_attr.y});
  assign w_hit_y = !w_d[DW-1] && (w_d <= $signed({{(DW-NW){1'b0}}, w_h}));
  assign w_n     = i_attr.vflip ? (w_h - w_d[NW-1:0]) : w_d[NW-1:0];

`ifdef SPRITE_XCLIP_EN
  localparam logic signed [DW-1:0] SCR = DW'(SCREEN_W);
  logic [NW-1:0]        w_w;
  logic signed [DW-1:0] w_xl;
  logic signed [DW-1:0] w_xr;
  logic signed [DW-1:0] w_over;
  logic [DW-1:0]        w_negx;
  logic                 w_hit_x;

  assign w_w     = {i_attr.sx, {TS{1'b1}}};
  assign w_xl    = {i_attr.x[COORD_W-1], i_attr.x};
  assign w_xr    = w_xl + $signed({{(DW-NW){1'b0}}, w_w});
  assign w_negx  = -w_xl;
  assign w_over  = w_xr - SCR;
  assign w_hit_x = !w_xr[DW-1] && (w_xl < SCR);

  assign o_hit       = w_hit_y && w_hit_x;
  assign o_rec.first = w_xl[DW-1] ? SIZE_W'(w_negx >> TS) : '0;
  assign o_rec.last  = (w_xr >= SCR) ? (i_attr.sx - SIZE_W'(w_over >> TS)) : i_attr.sx;
`else
  assign o_hit       = w_hit_y;
  assign o_rec.first = '0;
  assign o_rec.last  = i_attr.sx;
`endif

  assign o_rec.x        = i_attr.x;
  assign o_rec.tile_row = i_attr.tiley + 4'(w_n[NW-1:TS]);
  assign o_rec.row_off  = w_n[TS-1:0];
endmodule
`default_nettype wire

// File: rtl/sprite_line_eval.sv
`default_nettype none
// sprite_line_eval - walks the sprite table for one scan line and streams intersecting sprites.
// Rev 1.0; horizontal clipping is enabled with SPRITE_XCLIP_EN.
module sprite_line_eval #(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 8
) (
  input  logic               clk,
  input  logic               reset,
  sprite_line_eval_if.master bus
);
  import gpu_pkg::*;
  localparam int IW = $clog2(NUM_SPRITES);
  localparam int CW = $clog2(MAX_PER_LINE + 1);

  eval_state_t       r_state;
  eval_state_t       w_next;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic [LINE_W-1:0] r_line;
  sprite_attr_t      r_attr;
  logic [IW-1:0]     r_hit_idx;
  sprite_hit_t       r_hit;
  logic              w_hit;
  sprite_hit_t       w_rec;
  logic              w_last;
  logic              w_full;

  assign w_last = (r_idx == IW'(NUM_SPRITES - 1));
  assign w_full = (r_count == CW'(MAX_PER_LINE));

  sprite_geom u_geom (
    .i_attr (r_attr),
    .i_line (r_line),
    .o_hit  (w_hit),
    .o_rec  (w_rec)
  );

  always_comb begin
    w_next        = r_state;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.attr_rd   = 1'b0;
    bus.hit_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        bus.attr_rd = 1'b1;
        w_next      = ST_WAIT;
      end
      ST_WAIT: w_next = ST_EVAL;
      ST_EVAL: begin
        if (w_hit)       w_next = w_full ? ST_FIN : ST_EMIT;
        else             w_next = w_last ? ST_FIN : ST_FETCH;
      end
      ST_EMIT: begin
        bus.hit_valid = 1'b1;
        if (bus.hit_ready) w_next = w_last ? ST_FIN : ST_FETCH;
      end
      ST_FIN: begin
        bus.done = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_line     <= '0;
      r_attr     <= '0;
      r_hit_idx  <= '0;
      r_hit      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_idx      <= '0;
          r_count    <= '0;
          r_overflow <= 1'b0;
          r_line     <= bus.line;
        end
        ST_WAIT: r_attr <= '{x: bus.attr_x, y: bus.attr_y, sx: bus.attr_sx, sy: bus.attr_sy,
                             vflip: bus.attr_vflip, tiley: bus.attr_tiley};
        ST_EVAL: begin
          if (w_hit) begin
            if (w_full) begin
              r_overflow <= 1'b1;
            end else begin
              r_hit_idx <= r_idx;
              r_hit     <= w_rec;
            end
          end else if (!w_last) begin
            r_idx <= r_idx + IW'(1);
          end
        end
        ST_EMIT: if (bus.hit_ready) begin
          r_count <= r_count + CW'(1);
          if (!w_last) r_idx <= r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // the hit record is frozen in registers so it stays stable across a stalled handshake
  assign bus.attr_addr    = r_idx;
  assign bus.hit_count    = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.hit_index    = r_hit_idx;
  assign bus.hit_x        = r_hit.x;
  assign bus.hit_tile_row = r_hit.tile_row;
  assign bus.hit_row_off  = r_hit.row_off;
  assign bus.hit_first    = r_hit.first;
  assign bus.hit_last     = r_hit.last;
endmodule
`default_nettype wire

// File: tb/tb_sprite_line_eval.sv
`timescale 1ns/1ps
`default_nettype none
// tb_sprite_line_eval - vector table, corner sequences and random scans against a behavioural model.
module tb_sprite_line_eval;
  import gpu_pkg::*;
  localparam int NS     = 64;
  localparam int MPL    = 8;
  localparam int BUDGET = 4000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sprite_line_eval_if #(.NUM_SPRITES(NS), .MAX_PER_LINE(MPL)) bus ();
  sprite_line_eval #(.NUM_SPRITES(NS), .MAX_PER_LINE(MPL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int m_x [NS];
  int m_y [NS];
  int m_sx[NS];
  int m_sy[NS];
  int m_vf[NS];
  int m_ty[NS];

  always @(posedge clk) begin
    if (bus.attr_rd) begin
      bus.attr_x     <= COORD_W'(m_x[bus.attr_addr]);
      bus.attr_y     <= COORD_W'(m_y[bus.attr_addr]);
      bus.attr_sx    <= SIZE_W'(m_sx[bus.attr_addr]);
      bus.attr_sy    <= SIZE_W'(m_sy[bus.attr_addr]);
      bus.attr_vflip <= (m_vf[bus.attr_addr] != 0);
      bus.attr_tiley <= 4'(m_ty[bus.attr_addr]);
    end
  end

  typedef struct { int idx; int x; int row; int off; int first; int last; } rec_t;
  typedef struct { int y; int sy; int vf; int ty; int line; int n; int row; int off; } vec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  bit   exp_ovf;
  int   total = 0;
  int   bad   = 0;
  int   scan_cycles, first_addr, seen_done, stall_ok, stall_n, done_count, done_ovf, busy_c1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic bit rec_eq(input rec_t a, input rec_t b);
    return a.idx == b.idx && a.x == b.x && a.row == b.row && a.off == b.off &&
           a.first == b.first && a.last == b.last;
  endfunction

  // Reference: a sprite covers lines y .. y+height-1; rows counted from the top (or bottom if flipped)
  function automatic void model(input int ln);
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < NS; i++) begin
      int ht, wd, r;
      bit hit;
      rec_t e;
      ht  = (m_sy[i] + 1) * TILE_PX;
      wd  = (m_sx[i] + 1) * TILE_PX;
      hit = (ln >= m_y[i]) && (ln < m_y[i] + ht);
`ifdef SPRITE_XCLIP_EN
      hit = hit && (m_x[i] + wd > 0) && (m_x[i] < SCREEN_W);
`endif
      if (hit) begin
        if (exp_q.size() == MPL) begin
          exp_ovf = 1'b1;
          break;
        end
        r = ln - m_y[i];
        if (m_vf[i] != 0) r = ht - 1 - r;
        e.idx = i; e.x = m_x[i];
        e.row = (m_ty[i] + r / TILE_PX) % 16;
        e.off = r % TILE_PX;
        e.first = 0; e.last = m_sx[i];
`ifdef SPRITE_XCLIP_EN
        if (m_x[i] < 0) e.first = (-m_x[i]) / TILE_PX;
        if (m_x[i] + wd > SCREEN_W) e.last = m_sx[i] - (m_x[i] + wd - 1 - SCREEN_W) / TILE_PX;
`endif
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic clear_table();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = 0; m_y[i] = 2000; m_sx[i] = 0; m_sy[i] = 0; m_vf[i] = 0; m_ty[i] = 0;
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: hold ready low for 20 cycles on the first hit
  task automatic run_scan(input int ln, input int mode, input bit mid_start);
    rec_t snap, cur;
    got_q.delete();
    seen_done = 0; first_addr = -1; stall_ok = 1; stall_n = 0; scan_cycles = 0; busy_c1 = 0;
    done_count = -1; done_ovf = -1;
    @(negedge clk);
    bus.line  = LINE_W'(ln);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      if (mid_start) bus.start = (c == 4);
      if (c == 1) busy_c1 = int'(bus.busy);
      case (mode)
        0:       bus.hit_ready = 1'b1;
        1:       bus.hit_ready = 1'($urandom_range(0, 1));
        default: bus.hit_ready = !(bus.hit_valid && stall_n < 20);
      endcase
      cur = '{int'(bus.hit_index), int'($signed(bus.hit_x)), int'(bus.hit_tile_row),
              int'(bus.hit_row_off), int'(bus.hit_first), int'(bus.hit_last)};
      if (mode == 2 && bus.hit_valid && !bus.hit_ready) begin
        if (stall_n == 0) snap = cur;
        else if (!rec_eq(cur, snap)) stall_ok = 0;
        if (bus.attr_rd) stall_ok = 0;
        stall_n++;
      end
      if (bus.attr_rd && first_addr < 0) first_addr = int'(bus.attr_addr);
      if (bus.hit_valid && bus.hit_ready) got_q.push_back(cur);
      if (bus.done) begin
        seen_done  = 1;
        scan_cycles = c;
        done_count = int'(bus.hit_count);
        done_ovf   = int'(bus.overflow);
        break;
      end
      @(negedge clk);
    end
    bus.start     = 1'b0;
    bus.hit_ready = 1'b0;
    check("scan_done_seen", seen_done, 1);
  endtask

  task automatic compare_scan(input string tag);
    check({tag, "_count"}, done_count, exp_q.size());
    check({tag, "_ovf"}, done_ovf, int'(exp_ovf));
    check({tag, "_nrec"}, got_q.size(), exp_q.size());
    check({tag, "_first_addr"}, first_addr, 0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_r%0d_idx", tag, i), got_q[i].idx, exp_q[i].idx);
      check($sformatf("%s_r%0d_x", tag, i), got_q[i].x, exp_q[i].x);
      check($sformatf("%s_r%0d_row", tag, i), got_q[i].row, exp_q[i].row);
      check($sformatf("%s_r%0d_off", tag, i), got_q[i].off, exp_q[i].off);
      check($sformatf("%s_r%0d_first", tag, i), got_q[i].first, exp_q[i].first);
      check($sformatf("%s_r%0d_last", tag, i), got_q[i].last, exp_q[i].last);
    end
  endtask

  initial begin
    vec_t vecs[11];
    int   waited, saw;
    // {y, sy, vflip, tiley, line, hits, tile_row, row_off} for sprite 3, x=40, sx=1
    vecs[0]  = '{100,  1, 0, 2,  107,  1, 2,  7};
    vecs[1]  = '{100,  1, 1, 2,  100,  1, 3,  7};
    vecs[2]  = '{100,  1, 1, 2,  116,  0, 0,  0};
    vecs[3]  = '{100,  1, 0, 2,  99,   0, 0,  0};
    vecs[4]  = '{-5,   0, 0, 0,  2,    1, 0,  7};
    vecs[5]  = '{-20,  3, 0, 5,  0,    1, 7,  4};
    vecs[6]  = '{1015, 3, 0, 14, 1023, 1, 15, 0};
    vecs[7]  = '{1015, 3, 1, 14, 1023, 1, 0,  7};
    vecs[8]  = '{200,  7, 0, 0,  263,  1, 7,  7};
    vecs[9]  = '{200,  7, 0, 0,  264,  0, 0,  0};
    vecs[10] = '{1020, 0, 0, 0,  1023, 1, 0,  3};

    bus.start = 1'b0; bus.line = '0; bus.hit_ready = 1'b0;
    clear_table();
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hit_valid", bus.hit_valid, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_attr_rd", bus.attr_rd, 0);
    check("rst_hit_count", bus.hit_count, 0);
    check("rst_hit_fields", {bus.hit_index, bus.hit_x, bus.hit_tile_row, bus.hit_row_off,
                             bus.hit_first, bus.hit_last}, 0);
    reset = 1'b0;

    for (int v = 0; v < 11; v++) begin
      clear_table();
      m_x[3] = 40; m_sx[3] = 1;
      m_y[3] = vecs[v].y; m_sy[3] = vecs[v].sy; m_vf[3] = vecs[v].vf; m_ty[3] = vecs[v].ty;
      run_scan(vecs[v].line, 0, 0);
      check($sformatf("vec%0d_count", v), done_count, vecs[v].n);
      check($sformatf("vec%0d_nrec", v), got_q.size(), vecs[v].n);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d_idx", v), got_q[0].idx, 3);
        check($sformatf("vec%0d_x", v), got_q[0].x, 40);
        check($sformatf("vec%0d_row", v), got_q[0].row, vecs[v].row);
        check($sformatf("vec%0d_off", v), got_q[0].off, vecs[v].off);
        check($sformatf("vec%0d_first", v), got_q[0].first, 0);
        check($sformatf("vec%0d_last", v), got_q[0].last, 1);
      end
    end

    // empty line: latency, and a second start mid-scan must not restart it
    clear_table();
    run_scan(5, 0, 1);
    check("lat_cycles", scan_cycles, 3 * NS + 1);
    check("lat_busy", busy_c1, 1);
    check("lat_count", done_count, 0);
    check("lat_ovf", done_ovf, 0);

    clear_table();
    for (int i = 0; i < 10; i++) m_y[i] = 50;
    run_scan(50, 0, 0);
    model(50);
    compare_scan("ovf10");
    check("ovf10_flag", done_ovf, 1);
    check("ovf10_count", done_count, 8);

    clear_table();
    for (int i = 0; i < 8; i++) m_y[i * 7] = 50;
    run_scan(50, 1, 0);
    model(50);
    compare_scan("exact8");
    check("exact8_flag", done_ovf, 0);

    clear_table();
    m_y[3] = 100; m_sy[3] = 1; m_ty[3] = 2;
    m_y[9] = 100; m_sy[9] = 1; m_ty[9] = 6; m_x[9] = -3;
    run_scan(107, 2, 0);
    model(107);
    compare_scan("stall");
    check("stall_stable", stall_ok, 1);
    check("stall_len", stall_n, 20);

`ifdef SPRITE_XCLIP_EN
    clear_table();
    m_y[0] = 0; m_x[0] = -12; m_sx[0] = 3;
    m_y[1] = 0; m_x[1] = 620; m_sx[1] = 3;
    m_y[2] = 0; m_x[2] = -40; m_sx[2] = 3;
    m_y[4] = 0; m_x[4] = 639; m_sx[4] = 0;
    m_y[5] = 0; m_x[5] = 640; m_sx[5] = 0;
    m_y[6] = 0; m_x[6] = -31; m_sx[6] = 3;
    run_scan(3, 0, 0);
    check("xclip_count", done_count, 4);
    check("xclip_nrec", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("xclip_neg_idx", got_q[0].idx, 0);
      check("xclip_neg_first", got_q[0].first, 1);
      check("xclip_neg_last", got_q[0].last, 3);
      check("xclip_right_idx", got_q[1].idx, 1);
      check("xclip_right_first", got_q[1].first, 0);
      check("xclip_right_last", got_q[1].last, 2);   // visible pixels 620..639 end in column 2
      check("xclip_edge_idx", got_q[2].idx, 4);
      check("xclip_edge_last", got_q[2].last, 0);
      check("xclip_left_idx", got_q[3].idx, 6);
      check("xclip_left_first", got_q[3].first, 3);
    end
`endif

    // reset while a hit is waiting for the consumer
    clear_table();
    m_y[3] = 100; m_sy[3] = 1; m_ty[3] = 2;
    m_y[20] = 104; m_sy[20] = 0; m_ty[20] = 9;
    @(negedge clk);
    bus.hit_ready = 1'b0;
    bus.line = LINE_W'(107);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waited = 0;
    while (!bus.hit_valid && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("rstmid_emit_reached", bus.hit_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_valid", bus.hit_valid, 0);
    check("rstmid_busy", bus.busy, 0);
    saw = 0;
    repeat (10) begin
      if (bus.done || bus.hit_valid) saw = 1;
      @(negedge clk);
    end
    check("rstmid_quiet", saw, 0);
    run_scan(107, 0, 0);
    model(107);
    compare_scan("after_rst");

    for (int t = 0; t < 40; t++) begin
      int ln, dens;
      ln   = int'($urandom_range(0, 1023));
      dens = int'($urandom_range(1, 10));
      for (int i = 0; i < NS; i++) begin
        m_sx[i] = int'($urandom_range(0, 7));
        m_sy[i] = int'($urandom_range(0, 7));
        m_vf[i] = int'($urandom_range(0, 1));
        m_ty[i] = int'($urandom_range(0, 15));
        m_x[i]  = int'($urandom_range(0, 800)) - 100;
        if (int'($urandom_range(0, 15)) < dens) m_y[i] = ln - int'($urandom_range(0, 70)) + 10;
        else m_y[i] = ($urandom_range(0, 1) != 0) ? 2000 : -2000;
      end
      run_scan(ln, 1, 0);
      model(ln);
      compare_scan($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end
endmodule
`default_nettype wire
